// File: rtl/cam_pixel_packer.sv
// Camera FIFO word unpacker: recovers vsync/href framing and packs
// byte pairs into 12-bit pixels written to the frame buffer.
module cam_pixel_packer #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ABITS    = 15
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             wr_en,
  output logic [ABITS-1:0] wr_addr,
  output logic [11:0]      wr_data,
  output logic             busy,
  output logic             frame_done,
  output logic             short_frame,
  output logic [7:0]       line_cnt
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]    H_MAX  = XW'(H_PIXELS);
  localparam logic [YW-1:0]    Y_LAST = YW'(V_LINES - 1);
  localparam logic [ABITS-1:0] H_STEP = ABITS'(H_PIXELS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic          rd_q;
  logic          vs_seen;
  logic          href_q;
  logic          phase;
  logic [5:0]    byte_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ABITS-1:0] base;

  logic [5:0] w_byte;
  logic       w_vs;
  logic       w_hr;
  logic       go;
  logic       fall;
  logic       proc;
  logic       end_vs;
  logic       eol;
  logic       lat;
  logic       pix;

  assign w_byte = fifo_dout[7:2];
  assign w_vs   = fifo_dout[1];
  assign w_hr   = fifo_dout[0];

  assign go   = (state == IDLE) && start;
  // the vsync falling-edge word is itself the first capture word
  assign fall = (state == WAIT_VS) && rd_q && vs_seen && !w_vs;
  assign proc = rd_q && ((state == CAPTURE) || fall);

  assign end_vs = proc && w_vs;
  assign eol    = proc && !w_vs && !w_hr && href_q;
  assign lat    = proc && !w_vs && w_hr && !phase;
  assign pix    = proc && !w_vs && w_hr && phase;

  always_ff @(posedge pclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = WAIT_VS;
      WAIT_VS: if (fall) state_nx = CAPTURE;
      CAPTURE: begin
        if (end_vs || (eol && (y == Y_LAST)))
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd    = 1'b0;
    frame_done = 1'b0;
    if (!reset && !fifo_empty &&
        ((state == WAIT_VS) || (state == CAPTURE)))
      fifo_rd = 1'b1;
    if (state == DONE)
      frame_done = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rd_q        <= 1'b0;
      vs_seen     <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      byte_q      <= '0;
      x           <= '0;
      y           <= '0;
      base        <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      short_frame <= 1'b0;
      line_cnt    <= '0;
    end else begin
      rd_q  <= fifo_rd;
      wr_en <= 1'b0;
      busy  <= (state_nx == WAIT_VS) ||
               (state_nx == CAPTURE);
      if (go) begin
        vs_seen     <= 1'b0;
        href_q      <= 1'b0;
        phase       <= 1'b0;
        x           <= '0;
        y           <= '0;
        base        <= '0;
        short_frame <= 1'b0;
        line_cnt    <= '0;
      end
      if ((state == WAIT_VS) && rd_q && w_vs)
        vs_seen <= 1'b1;
      if (proc)
        href_q <= w_hr;
      if (lat) begin
        byte_q <= w_byte;
        phase  <= 1'b1;
      end
      if (pix) begin
        phase <= 1'b0;
        if (x < H_MAX) begin
          wr_en   <= 1'b1;
          wr_addr <= base + ABITS'(x);
          wr_data <= {byte_q, w_byte};
          x       <= x + 1'b1;
        end
      end
      // end of line: any dangling odd byte is dropped with the phase
      if (eol) begin
        y     <= y + 1'b1;
        base  <= base + H_STEP;
        x     <= '0;
        phase <= 1'b0;
        if (line_cnt != 8'hFF)
          line_cnt <= line_cnt + 1'b1;
      end
      if (end_vs)
        short_frame <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Scoreboard bench for cam_pixel_packer on a 4x2 frame with a
// queue-backed FIFO model.
module tb_cam_pixel_packer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 15;

  logic          pclk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          short_frame;
  logic [7:0]    line_cnt;

  logic       stall;
  logic       emp_q;
  logic [7:0] fq[$];
  logic [AW+11:0] exp_q[$];
  logic [AW+11:0] e;
  int n_chk;
  int n_fail;
  int wcnt;

  cam_pixel_packer #(
    .H_PIXELS(H),
    .V_LINES (V),
    .ABITS   (AW)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .start      (start),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .short_frame(short_frame),
    .line_cnt   (line_cnt)
  );

  always #5 pclk = ~pclk;

  assign fifo_empty = stall || emp_q;

  always @(posedge pclk)
    if (fifo_rd && fq.size() > 0)
      fifo_dout <= fq.pop_front();

  always @(negedge pclk)
    emp_q <= (fq.size() == 0);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, expv);
    end
  endtask

  always @(negedge pclk) begin
    if (wr_en) begin
      wcnt++;
      check("wr_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[AW+11:12]));
        check("wr_data", 32'(wr_data), 32'(e[11:0]));
      end
    end
  end

  task automatic pw(input logic [5:0] b,
                    input logic vs, input logic hr);
    fq.push_back({b, vs, hr});
  endtask

  task automatic preamble();
    pw(6'd0, 1'b1, 1'b0);
    pw(6'd0, 1'b1, 1'b0);
    pw(6'd0, 1'b0, 1'b0);
  endtask

  task automatic push_line(input int n, input int first,
                           input int y);
    logic [5:0] b0;
    logic [5:0] b1;
    for (int i = 0; i < n; i++)
      pw(6'(first + i), 1'b0, 1'b1);
    pw(6'd0, 1'b0, 1'b0);
    for (int p = 0; p < n / 2; p++) begin
      if (p < H) begin
        b0 = 6'(first + 2 * p);
        b1 = 6'(first + 2 * p + 1);
        exp_q.push_back({AW'(y * H + p), b0, b1});
      end
    end
  endtask

  task automatic clear_all();
    fq.delete();
    exp_q.delete();
    wcnt = 0;
  endtask

  task automatic go();
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    check("busy_on", 32'(busy), 1);
    check("short_clr", 32'(short_frame), 0);
    check("lcnt_clr", 32'(line_cnt), 0);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge pclk);
      if (frame_done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 1);
    @(negedge pclk);
    check("done_pulse", 32'(frame_done), 0);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 300 && wcnt < n; i++) begin
      @(negedge pclk);
      #1;
    end
    check("reach_wr", 32'(wcnt >= n), 1);
  endtask

  task automatic full_frame();
    clear_all();
    preamble();
    push_line(8, 1, 0);
    push_line(8, 9, 1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    wcnt = 0;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    pw(6'h15, 1'b0, 1'b1);
    pw(6'h2a, 1'b1, 1'b0);
    repeat (4) @(negedge pclk);
    check("rst_rd", 32'(fifo_rd), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_short", 32'(short_frame), 0);
    check("rst_lcnt", 32'(line_cnt), 0);
    reset = 1'b0;
    repeat (2) @(negedge pclk);
    check("idle_rd", 32'(fifo_rd), 0);

    full_frame();
    go();
    wait_done();
    check("full_short", 32'(short_frame), 0);
    check("full_lcnt", 32'(line_cnt), 2);
    check("full_wcnt", 32'(wcnt), 8);
    check("full_left", 32'(exp_q.size()), 0);
    check("full_busy", 32'(busy), 0);

    clear_all();
    preamble();
    push_line(11, 1, 0);
    push_line(8, 20, 1);
    go();
    wait_done();
    check("long_wcnt", 32'(wcnt), 8);
    check("long_lcnt", 32'(line_cnt), 2);
    check("long_left", 32'(exp_q.size()), 0);

    clear_all();
    preamble();
    push_line(8, 1, 0);
    pw(6'd0, 1'b1, 1'b0);
    go();
    wait_done();
    check("sf_short", 32'(short_frame), 1);
    check("sf_lcnt", 32'(line_cnt), 1);
    check("sf_wcnt", 32'(wcnt), 4);

    full_frame();
    go();
    wait_writes(2);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("stall_rd", 32'(fifo_rd), 0);
      start = (i == 1);
    end
    start = 1'b0;
    check("stall_busy", 32'(busy), 1);
    stall = 1'b0;
    wait_done();
    check("stall_wcnt", 32'(wcnt), 8);
    check("stall_lcnt", 32'(line_cnt), 2);
    check("stall_left", 32'(exp_q.size()), 0);

    full_frame();
    go();
    wait_writes(3);
    reset = 1'b1;
    @(negedge pclk);
    check("mid_wr_en", 32'(wr_en), 0);
    check("mid_busy", 32'(busy), 0);
    @(negedge pclk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check("mid_idle_wr", 32'(wr_en), 0);
      check("mid_idle_rd", 32'(fifo_rd), 0);
    end
    check("mid_wcnt", 32'(wcnt), 3);

    full_frame();
    go();
    wait_done();
    check("re_wcnt", 32'(wcnt), 8);
    check("re_lcnt", 32'(line_cnt), 2);
    check("re_left", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
